pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised inter-stage pipeline register (IF/ID and later stages) with valid/ready handshake.
//  Two-entry skid buffer: full throughput, registered in_ready, no combinational ready path.
//  Flush squashes held entries to a NOP bubble. Invalid outputs are defined values, never X.
// PARAMETERS
//  DATA_W   32            width of payload (instruction word)
//  PC_W     32            width of PC sideband
//  NOP_VAL  {DATA_W{1'b0}} payload driven while out_valid=0 and after reset/flush
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst        in   1       synchronous, active-high reset
//  flush      in   1       squash all held entries this cycle
//  in_valid   in   1       upstream entry valid
//  in_ready   out  1       stage can accept (registered)
//  in_data    in   DATA_W  upstream payload
//  in_pc      in   PC_W    upstream PC
//  out_valid  out  1       out_data/out_pc valid
//  out_ready  in   1       downstream accepts
//  out_data   out  DATA_W  payload (NOP_VAL when !out_valid)
//  out_pc     out  PC_W    PC (0 when !out_valid)
//  stall_cnt  out  32      [PIPE_SKID_STATS_EN only] cycles out_valid&!out_ready
//  bubble_cnt out  32      [PIPE_SKID_STATS_EN only] cycles !out_valid after reset
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=NOP_VAL, out_pc=0, in_ready=1, skid empty, counters 0.
//  - Accept when in_valid&in_ready; emit when out_valid&out_ready. Both may occur same cycle.
//  - States: EMPTY(main,skid free) / ONE(main held) / TWO(main+skid held). in_ready = (state!=TWO).
//    EMPTY: accept -> ONE.
//    ONE:   accept&emit -> ONE (new entry into main); accept&!emit -> TWO (entry into skid);
//           !accept&emit -> EMPTY; else hold.
//    TWO:   emit -> ONE (skid moves to main, skid cleared); else hold. No accept possible.
//  - Latency 1 cycle in->out from EMPTY; sustained 1 entry/cycle when out_ready=1.
//  - Order preserved: skid entry always older than any new input.
//  - Held outputs stable while out_valid&!out_ready (no change to out_data/out_pc).
//  - flush: next state EMPTY, out_valid=0, out_data=NOP_VAL, out_pc=0, in_ready=1;
//    overrides accept/emit same cycle (input that cycle is dropped). rst overrides flush.
//  - Reset mid-transfer: all held entries discarded, no partial state survives.
//  - in_valid ignored while in_ready=0; upstream must hold data (not checked).
// CONFIGURATION
//  PIPE_SKID_STATS_EN defined: stall_cnt/bubble_cnt ports and 32-bit counters present;
//   counters saturate at 32'hFFFF_FFFF, clear on rst (not on flush).
//  Undefined: ports and counters absent; datapath behaviour identical.
// TESTING
//  1 rst 1 cycle -> out_valid=0,out_data=NOP_VAL,out_pc=0,in_ready=1.
//  2 stream A0..A7 (pc 0x00..0x1C), out_ready=1 -> each out 1 cycle later, in order, no gaps.
//  3 push 0x11,0x22 with out_ready=0 -> in_ready=0 after 2nd, out_data=0x11 stable;
//    raise out_ready -> 0x11 then 0x22, in_ready=1 one cycle after first emit.
//  4 state TWO + flush + in_valid=1 (0x33) -> next cycle out_valid=0,in_ready=1, 0x33 never emitted.
//  5 rst asserted while TWO -> all entries lost, outputs at reset values next cycle.
//  6 STATS_EN: 5 stall cycles then 3 idle cycles -> stall_cnt=5, bubble_cnt>=3; flush keeps counts.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer, registered in_ready and flush-to-NOP.
// Optional stall/bubble statistics counters are enabled by defining PIPE_SKID_STATS_EN.
module pipe_stage_skid #(
  parameter int unsigned        DATA_W  = 32,
  parameter int unsigned        PC_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic [PC_W-1:0]   i_in_pc,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out_data,
  output logic [PC_W-1:0]   o_out_pc
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_outValid;
  logic              r_inReady;
  logic [DATA_W-1:0] r_mainData;
  logic [PC_W-1:0]   r_mainPc;
  logic [DATA_W-1:0] r_skidData;
  logic [PC_W-1:0]   r_skidPc;

  logic w_accept;
  logic w_emit;

  assign w_accept = i_in_valid & r_inReady;
  assign w_emit   = r_outValid & i_out_ready;

  // Main register always holds the oldest entry; the skid only fills when
  // downstream stalls while an accept is already in flight. Empty slots are
  // kept at NOP/0 so invalid outputs are never X.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_state    <= EMPTY;
      r_outValid <= 1'b0;
      r_inReady  <= 1'b1;
      r_mainData <= NOP_VAL;
      r_mainPc   <= '0;
      r_skidData <= NOP_VAL;
      r_skidPc   <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            r_mainData <= i_in_data;
            r_mainPc   <= i_in_pc;
            r_outValid <= 1'b1;
            r_state    <= ONE;
          end
        end
        ONE: begin
          if (w_accept && w_emit) begin
            r_mainData <= i_in_data;
            r_mainPc   <= i_in_pc;
          end else if (w_accept) begin
            r_skidData <= i_in_data;
            r_skidPc   <= i_in_pc;
            r_inReady  <= 1'b0;
            r_state    <= TWO;
          end else if (w_emit) begin
            r_mainData <= NOP_VAL;
            r_mainPc   <= '0;
            r_outValid <= 1'b0;
            r_state    <= EMPTY;
          end
        end
        TWO: begin
          if (w_emit) begin
            r_mainData <= r_skidData;
            r_mainPc   <= r_skidPc;
            r_skidData <= NOP_VAL;
            r_skidPc   <= '0;
            r_inReady  <= 1'b1;
            r_state    <= ONE;
          end
        end
        default: begin
          r_state    <= EMPTY;
          r_outValid <= 1'b0;
          r_inReady  <= 1'b1;
          r_mainData <= NOP_VAL;
          r_mainPc   <= '0;
          r_skidData <= NOP_VAL;
          r_skidPc   <= '0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_inReady;
  assign o_out_valid = r_outValid;
  assign o_out_data  = r_mainData;
  assign o_out_pc    = r_mainPc;

`ifdef PIPE_SKID_STATS_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_bubbleCnt;

  // Saturating counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      if (r_outValid && !i_out_ready && (r_stallCnt != 32'hFFFF_FFFF))
        r_stallCnt <= r_stallCnt + 32'd1;
      if (!r_outValid && (r_bubbleCnt != 32'hFFFF_FFFF))
        r_bubbleCnt <= r_bubbleCnt + 32'd1;
    end
  end

  assign o_stall_cnt  = r_stallCnt;
  assign o_bubble_cnt = r_bubbleCnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; stats checks build only with PIPE_SKID_STATS_EN.
module tb_pipe_stage_skid;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [31:0] inPc;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [31:0] outPc;
`ifdef PIPE_SKID_STATS_EN
  logic [31:0] stallCnt;
  logic [31:0] bubbleCnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_stage_skid #(.DATA_W(32), .PC_W(32), .NOP_VAL(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_in_valid  (inValid),
    .o_in_ready  (inReady),
    .i_in_data   (inData),
    .i_in_pc     (inPc),
    .o_out_valid (outValid),
    .i_out_ready (outReady),
    .o_out_data  (outData),
    .o_out_pc    (outPc)
`ifdef PIPE_SKID_STATS_EN
    ,
    .o_stall_cnt (stallCnt),
    .o_bubble_cnt(bubbleCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs and advance to the following negedge.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic [31:0] pc,
                               input logic ordy, input logic fl);
    inValid  = v;
    inData   = d;
    inPc     = pc;
    outReady = ordy;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (outValid !== 1'b0)   begin failures++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", outValid); end
    checks++; if (outData !== 32'h0)   begin failures++; $display("[TB] FAIL reset_out_data: got %h, expected 0", outData); end
    checks++; if (outPc !== 32'h0)     begin failures++; $display("[TB] FAIL reset_out_pc: got %h, expected 0", outPc); end
    checks++; if (inReady !== 1'b1)    begin failures++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", inReady); end
  endtask

  task automatic test_stream;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'hA0 + i, i * 4, 1'b1, 1'b0);
      checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL stream_valid[%0d]: got %b, expected 1", i, outValid); end
      checks++; if (outData !== 32'hA0 + i) begin failures++; $display("[TB] FAIL stream_data[%0d]: got %h, expected %h", i, outData, 32'hA0 + i); end
      checks++; if (outPc !== i * 4) begin failures++; $display("[TB] FAIL stream_pc[%0d]: got %h, expected %h", i, outPc, i * 4); end
      checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL stream_in_ready[%0d]: got %b, expected 1", i, inReady); end
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL stream_drain_valid: got %b, expected 0", outValid); end
    checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL stream_drain_data: got %h, expected 0", outData); end
    checks++; if (outPc !== 32'h0)   begin failures++; $display("[TB] FAIL stream_drain_pc: got %h, expected 0", outPc); end
  endtask

  task automatic test_back_to_back;
    applyStimulus(1'b1, 32'h11, 32'h40, 1'b0, 1'b0);
    checks++; if (outData !== 32'h11) begin failures++; $display("[TB] FAIL skid_first_data: got %h, expected 11", outData); end
    checks++; if (inReady !== 1'b1)   begin failures++; $display("[TB] FAIL skid_first_ready: got %b, expected 1", inReady); end
    applyStimulus(1'b1, 32'h22, 32'h44, 1'b0, 1'b0);
    checks++; if (inReady !== 1'b0)   begin failures++; $display("[TB] FAIL skid_full_ready: got %b, expected 0", inReady); end
    checks++; if (outData !== 32'h11) begin failures++; $display("[TB] FAIL skid_full_data: got %h, expected 11", outData); end
    // A value offered while in_ready=0 must be ignored entirely.
    applyStimulus(1'b1, 32'h99, 32'h48, 1'b0, 1'b0);
    checks++; if (outData !== 32'h11) begin failures++; $display("[TB] FAIL skid_hold_data: got %h, expected 11", outData); end
    checks++; if (outPc !== 32'h40)   begin failures++; $display("[TB] FAIL skid_hold_pc: got %h, expected 40", outPc); end
    checks++; if (outValid !== 1'b1)  begin failures++; $display("[TB] FAIL skid_hold_valid: got %b, expected 1", outValid); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (outData !== 32'h22) begin failures++; $display("[TB] FAIL skid_second_data: got %h, expected 22", outData); end
    checks++; if (outPc !== 32'h44)   begin failures++; $display("[TB] FAIL skid_second_pc: got %h, expected 44", outPc); end
    checks++; if (inReady !== 1'b1)   begin failures++; $display("[TB] FAIL skid_reopen_ready: got %b, expected 1", inReady); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b0)  begin failures++; $display("[TB] FAIL skid_empty_valid: got %b, expected 0", outValid); end
  endtask

  task automatic test_flush;
    applyStimulus(1'b1, 32'h01, 32'h80, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h02, 32'h84, 1'b0, 1'b0);
    checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_setup_ready: got %b, expected 0", inReady); end
    applyStimulus(1'b1, 32'h33, 32'h88, 1'b1, 1'b1);
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_two_valid: got %b, expected 0", outValid); end
    checks++; if (inReady !== 1'b1)  begin failures++; $display("[TB] FAIL flush_two_ready: got %b, expected 1", inReady); end
    checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL flush_two_data: got %h, expected 0", outData); end
    checks++; if (outPc !== 32'h0)   begin failures++; $display("[TB] FAIL flush_two_pc: got %h, expected 0", outPc); end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_no_emit[%0d]: got valid %b data %h, expected valid 0", i, outValid, outData); end
    end
    // Flush from ONE with in_ready=1: the offered input is dropped too.
    applyStimulus(1'b1, 32'h44, 32'h90, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 32'h94, 1'b0, 1'b1);
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_one_valid: got %b, expected 0", outValid); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_one_dropped: got valid %b data %h, expected valid 0", outValid, outData); end
  endtask

  task automatic test_reset_mid;
    applyStimulus(1'b1, 32'h66, 32'hA0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h77, 32'hA4, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h88, 32'hA8, 1'b1, 1'b0);
    rst = 1'b0;
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_valid: got %b, expected 0", outValid); end
    checks++; if (outData !== 32'h0) begin failures++; $display("[TB] FAIL rstmid_data: got %h, expected 0", outData); end
    checks++; if (outPc !== 32'h0)   begin failures++; $display("[TB] FAIL rstmid_pc: got %h, expected 0", outPc); end
    checks++; if (inReady !== 1'b1)  begin failures++; $display("[TB] FAIL rstmid_ready: got %b, expected 1", inReady); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_no_leftover: got valid %b data %h, expected valid 0", outValid, outData); end
  endtask

`ifdef PIPE_SKID_STATS_EN
  task automatic test_stats;
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    checks++; if (stallCnt !== 32'd0)  begin failures++; $display("[TB] FAIL stats_reset_stall: got %0d, expected 0", stallCnt); end
    checks++; if (bubbleCnt !== 32'd0) begin failures++; $display("[TB] FAIL stats_reset_bubble: got %0d, expected 0", bubbleCnt); end
    applyStimulus(1'b1, 32'hC0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    checks++; if (stallCnt !== 32'd5) begin failures++; $display("[TB] FAIL stats_stall: got %0d, expected 5", stallCnt); end
    checks++; if (bubbleCnt < 32'd3)  begin failures++; $display("[TB] FAIL stats_bubble: got %0d, expected >=3", bubbleCnt); end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++; if (stallCnt !== 32'd5) begin failures++; $display("[TB] FAIL stats_flush_stall: got %0d, expected 5", stallCnt); end
    checks++; if (bubbleCnt < 32'd3)  begin failures++; $display("[TB] FAIL stats_flush_bubble: got %0d, expected >=3", bubbleCnt); end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    inValid  = 1'b0;
    inData   = 32'h0;
    inPc     = 32'h0;
    outReady = 1'b0;
    test_reset;
    test_stream;
    test_back_to_back;
    test_flush;
    test_reset_mid;
`ifdef PIPE_SKID_STATS_EN
    test_stats;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
